icache_fetch_unit: RTL and testbench

//  Direct-mapped instruction cache with a single outstanding miss, sitting directly upstream of the fetch instruction buffer.
//  - Each cycle it takes the buffer's fetch PC and the number of instructions the buffer wants.
//  - It returns up to N_WAY consecutive instructions, valid-packed from lane 0.
//  - Misses are serviced over the tagged memory bus through a small refill FSM.

---
 rtl/icache_fetch_unit_if.sv | 47 ++++
 rtl/icache_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_icache_fetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fetch_unit_if
//  Description : Fetch-buffer lookup signals and tagged memory-bus refill
//                signals for the instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_fetch_unit_if #(
    parameter int N_WAY = 3,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(N_WAY) + 1;

    // Fetch buffer side
    logic [XLEN-1:0]             buff2Icache_addr;
    logic [CNT_W-1:0]            buff2Icache_count;
    logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_addr;
    logic [N_WAY-1:0][XLEN-1:0]  Icache2buff_data;
    logic [N_WAY-1:0]            Icache2buff_valid;
    logic [CNT_W-1:0]            Icache2buff_hit_count;

    // Memory bus side
    logic                        Imem_grant;
    logic [1:0]                  proc2Imem_command;
    logic [XLEN-1:0]             proc2Imem_addr;
    logic [TAG_W-1:0]            Imem2proc_response;
    logic [63:0]                 Imem2proc_data;
    logic [TAG_W-1:0]            Imem2proc_tag;

    // The cache itself
    modport slave (
        input  buff2Icache_addr, buff2Icache_count,
        output Icache2buff_addr, Icache2buff_data, Icache2buff_valid, Icache2buff_hit_count,
        input  Imem_grant, Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output proc2Imem_command, proc2Imem_addr
    );

    // The environment: fetch buffer plus memory/arbiter
    modport master (
        output buff2Icache_addr, buff2Icache_count,
        input  Icache2buff_addr, Icache2buff_data, Icache2buff_valid, Icache2buff_hit_count,
        output Imem_grant, Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  proc2Imem_command, proc2Imem_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fetch_unit
//  Description : Direct-mapped instruction cache feeding the fetch buffer.
//                Returns up to N_WAY consecutive instructions per cycle,
//                valid-packed from lane 0, with a single outstanding refill
//                over a tagged memory bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_unit #(
    parameter int N_WAY     = 3,
    parameter int XLEN      = 32,
    parameter int NUM_LINES = 32,
    parameter int TAG_W     = 4
) (
    input  logic                clock,
    input  logic                reset,      // synchronous, active-low
    icache_fetch_unit_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int CTAG_W = XLEN - 3 - IDX_W;
    localparam int CNT_W  = $clog2(N_WAY) + 1;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Line storage: 8-byte lines, word 0 in the low half
    logic [63:0]          data_q  [NUM_LINES];
    logic [CTAG_W-1:0]    ctag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      miss_addr_q, miss_addr_d;
    logic [TAG_W-1:0]     mem_tag_q, mem_tag_d;
    logic                 fill;
    logic [1:0]           cmd;

    logic [N_WAY-1:0][XLEN-1:0] lane_addr;
    logic [N_WAY-1:0][XLEN-1:0] lane_data;
    logic [N_WAY-1:0]           lane_valid;
    logic [CNT_W-1:0]           hit_cnt;
    logic                       miss;
    logic [XLEN-1:0]            miss_line;

    // Per-lane lookup; the hit chain breaks at the first requested lane that misses
    always_comb begin : p_lookup
        logic [IDX_W-1:0]  idx;
        logic [CTAG_W-1:0] ltag;
        logic              chain;
        idx        = '0;
        ltag       = '0;
        chain      = 1'b1;
        lane_addr  = '0;
        lane_data  = '0;
        lane_valid = '0;
        hit_cnt    = '0;
        miss       = 1'b0;
        miss_line  = '0;
        for (int i = 0; i < N_WAY; i++) begin
            lane_addr[i] = bus.buff2Icache_addr + XLEN'(4 * i);
            idx          = lane_addr[i][3 +: IDX_W];
            ltag         = lane_addr[i][XLEN-1 -: CTAG_W];
            if (CNT_W'(i) < bus.buff2Icache_count && chain) begin
                if (valid_q[idx] && (ctag_q[idx] == ltag)) begin
                    lane_valid[i] = 1'b1;
                    lane_data[i]  = lane_addr[i][2] ? data_q[idx][63:32] : data_q[idx][31:0];
                    hit_cnt       = hit_cnt + CNT_W'(1);
                end else begin
                    chain     = 1'b0;
                    miss      = 1'b1;
                    miss_line = {lane_addr[i][XLEN-1:3], 3'b000};
                end
            end
        end
    end

    // Refill FSM next-state and bus command
    always_comb begin : p_fsm_next
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_tag_d   = mem_tag_q;
        fill        = 1'b0;
        cmd         = CMD_NONE;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    miss_addr_d = miss_line;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                cmd = CMD_LOAD;
                if (bus.Imem_grant && (bus.Imem2proc_response != '0)) begin
                    mem_tag_d = bus.Imem2proc_response;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // The latched tag is never 0, so an idle bus cannot match
                if (bus.Imem2proc_tag == mem_tag_q) begin
                    fill    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, latched refill address/tag and line valid bits
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            mem_tag_q   <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_tag_q   <= mem_tag_d;
            if (fill) begin
                valid_q[miss_addr_q[3 +: IDX_W]] <= 1'b1;
            end
        end
    end

    // Line data and tag storage, written only by a completed refill
    always_ff @(posedge clock) begin
        if (reset && fill) begin
            data_q[miss_addr_q[3 +: IDX_W]] <= bus.Imem2proc_data;
            ctag_q[miss_addr_q[3 +: IDX_W]] <= miss_addr_q[XLEN-1 -: CTAG_W];
        end
    end

    // Outputs are held inactive while reset is asserted
    assign bus.Icache2buff_addr      = lane_addr;
    assign bus.Icache2buff_data      = reset ? lane_data  : '0;
    assign bus.Icache2buff_valid     = reset ? lane_valid : '0;
    assign bus.Icache2buff_hit_count = reset ? hit_cnt    : '0;
    assign bus.proc2Imem_command     = reset ? cmd        : CMD_NONE;
    assign bus.proc2Imem_addr        = reset ? miss_addr_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_fetch_unit
//  Description : Randomised scoreboard bench for icache_fetch_unit with a
//                line-address cache model and a tagged memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_unit;
    localparam int N_WAY     = 3;
    localparam int XLEN      = 32;
    localparam int NUM_LINES = 32;
    localparam int TAG_W     = 4;
    localparam int CNT_W     = $clog2(N_WAY) + 1;
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int NCYC      = 4000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    icache_fetch_unit_if #(.N_WAY(N_WAY), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    icache_fetch_unit #(
        .N_WAY(N_WAY), .XLEN(XLEN), .NUM_LINES(NUM_LINES), .TAG_W(TAG_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [N_WAY-1:0]           valid;
        logic [CNT_W-1:0]           hc;
        logic [N_WAY-1:0][XLEN-1:0] addr;
        logic [N_WAY-1:0][XLEN-1:0] data;
        logic [1:0]                 cmd;
        bit                         chk_maddr;
        logic [XLEN-1:0]            maddr;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: which full line address each set holds
    logic [31:0] m_line [NUM_LINES];
    bit          m_v    [NUM_LINES];
    bit          have_req, inflight;
    logic [31:0] req_line;
    logic [TAG_W-1:0] req_tag;
    bit          cur_miss;
    logic [31:0] cur_miss_line;
    int          ret_dly;
    bit          stale_pend;
    logic [TAG_W-1:0] stale_tag;
    int          stale_dly;

    // Instruction word stored in backing memory at a given address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Apply the effect of the clock edge just passed to the model
    task automatic model_edge();
        if (!reset) begin
            if (inflight) begin
                stale_pend = 1'b1;
                stale_tag  = req_tag;
                stale_dly  = $urandom_range(1, 4);
            end
            for (int k = 0; k < NUM_LINES; k++) m_v[k] = 1'b0;
            have_req = 1'b0;
            inflight = 1'b0;
            req_line = '0;
        end else if (inflight && bus.Imem2proc_tag == req_tag) begin
            m_v[req_line[3 +: IDX_W]]    = 1'b1;
            m_line[req_line[3 +: IDX_W]] = req_line;
            inflight = 1'b0;
        end else if (have_req && bus.Imem_grant && bus.Imem2proc_response != '0) begin
            have_req = 1'b0;
            inflight = 1'b1;
            req_tag  = bus.Imem2proc_response;
            ret_dly  = $urandom_range(0, 6);
        end else if (!have_req && !inflight && cur_miss) begin
            have_req = 1'b1;
            req_line = cur_miss_line;
        end
    endtask

    function automatic logic [TAG_W-1:0] pick_resp_tag();
        logic [TAG_W-1:0] t;
        t = TAG_W'($urandom_range(1, (1 << TAG_W) - 1));
        if (stale_pend && t == stale_tag) t = t + TAG_W'(1);
        if (t == '0) t = TAG_W'(1);
        if (stale_pend && t == stale_tag) t = t + TAG_W'(1);
        return t;
    endfunction

    task automatic drive_inputs(input int cyc);
        logic [TAG_W-1:0] jt;
        // Reset: two cycles at start, then occasional, biased toward mid-refill
        if (cyc < 2) reset = 1'b0;
        else if ((inflight && $urandom_range(0, 29) == 0) || $urandom_range(0, 299) == 0) reset = 1'b0;
        else reset = 1'b1;

        // Fetch buffer: PC held most cycles, in a region that aliases sets twice
        if (cyc == 2) bus.buff2Icache_addr = 32'h0;
        else if ($urandom_range(0, 9) < 3) bus.buff2Icache_addr = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
        bus.buff2Icache_count = CNT_W'($urandom_range(0, N_WAY));

        // Arbiter / acceptance
        bus.Imem_grant         = ($urandom_range(0, 1) == 1);
        bus.Imem2proc_response = ($urandom_range(0, 9) < 6) ? pick_resp_tag() : '0;

        // Data return: stale tag from a dropped refill, real return, or junk
        bus.Imem2proc_tag  = '0;
        bus.Imem2proc_data = {$urandom, $urandom};
        if (stale_pend && stale_dly == 0) begin
            bus.Imem2proc_tag = stale_tag;
            stale_pend = 1'b0;
        end else begin
            if (stale_pend) stale_dly--;
            if (inflight && ret_dly == 0) begin
                bus.Imem2proc_tag  = req_tag;
                bus.Imem2proc_data = {mem_word(req_line + 32'd4), mem_word(req_line)};
            end else begin
                if (inflight) ret_dly--;
                if ($urandom_range(0, 9) < 3) begin
                    jt = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
                    if (inflight && jt == req_tag) jt = jt + TAG_W'(1);
                    bus.Imem2proc_tag  = jt;
                    bus.Imem2proc_data = ~{mem_word(req_line + 32'd4), mem_word(req_line)};
                end
            end
        end
    endtask

    // Expected outputs for the inputs just driven
    task automatic push_expected();
        exp_t        e;
        bit          alive;
        logic [31:0] la, line;
        int          idx;
        e.valid = '0; e.hc = '0; e.addr = '0; e.data = '0;
        alive = 1'b1; cur_miss = 1'b0; cur_miss_line = '0;
        for (int i = 0; i < N_WAY; i++) begin
            la        = bus.buff2Icache_addr + 32'(4 * i);
            e.addr[i] = la;
            line      = {la[31:3], 3'b000};
            idx       = int'(la[3 +: IDX_W]);
            if (reset && alive && i < int'(bus.buff2Icache_count)) begin
                if (m_v[idx] && m_line[idx] == line) begin
                    e.valid[i] = 1'b1;
                    e.hc       = e.hc + CNT_W'(1);
                    e.data[i]  = mem_word(la);
                end else begin
                    alive = 1'b0;
                    cur_miss = 1'b1;
                    cur_miss_line = line;
                end
            end
        end
        e.cmd       = (reset && have_req) ? 2'd1 : 2'd0;
        e.chk_maddr = !reset || have_req;
        e.maddr     = reset ? req_line : '0;
        q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lane_valid", 96'(bus.Icache2buff_valid), 96'(e.valid));
                chk("hit_count",  96'(bus.Icache2buff_hit_count), 96'(e.hc));
                chk("lane_addr",  96'(bus.Icache2buff_addr), 96'(e.addr));
                chk("lane_data",  96'(bus.Icache2buff_data), 96'(e.data));
                chk("command",    96'(bus.proc2Imem_command), 96'(e.cmd));
                if (e.chk_maddr) chk("mem_addr", 96'(bus.proc2Imem_addr), 96'(e.maddr));
            end
        end
    end

    // Driver and model update, one iteration per clock
    initial begin
        bus.buff2Icache_addr   = '0;
        bus.buff2Icache_count  = '0;
        bus.Imem_grant         = 1'b0;
        bus.Imem2proc_response = '0;
        bus.Imem2proc_data     = '0;
        bus.Imem2proc_tag      = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            m_v[k] = 1'b0;
            m_line[k] = '0;
        end
        have_req = 0; inflight = 0; req_line = '0; req_tag = '0;
        cur_miss = 0; cur_miss_line = '0; ret_dly = 0;
        stale_pend = 0; stale_tag = '0; stale_dly = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock);
            #1;
            model_edge();
            drive_inputs(cyc);
            push_expected();
        end
        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
